// File: rtl/pc_regfile_pkg.sv
// Shared register-file constants and types.
// Holds special register indices and the address type.
package pc_regfile_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t REG_SP = 4'd13;
  localparam reg_addr_t REG_LR = 4'd14;
  localparam reg_addr_t REG_PC = 4'd15;

endpackage

// File: rtl/pc_regfile_rdport.sv
// One combinational read port: PC offset for R15, write-first bypass.
// Ports: addr in, view (active-bank R0..R14), pc, write/link info; data out.
module pc_regfile_rdport
  import pc_regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_RD_OFS = 8
) (
  input  reg_addr_t          addr,
  input  logic [15*DATA_W-1:0] view,
  input  logic [DATA_W-1:0]  pc,
  input  logic               wr_en,
  input  reg_addr_t          waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               link_we,
  input  logic [DATA_W-1:0]  link_val,
  output logic [DATA_W-1:0]  data
);

  // Link value beats general write data, matching register update order.
  always_comb begin
    data = '0;
    if (addr == REG_PC)
      data = pc + DATA_W'(PC_RD_OFS);
    else if (link_we && addr == REG_LR)
      data = link_val;
    else if (wr_en && addr == waddr)
      data = wdata;
    else
      data = view[int'(addr)*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/pc_regfile.sv
// Register file R0..R14 with IRQ-banked R13/R14 and a separate PC.
// Ports: clk/reset, write, link, PC control, mode_irq, packed read ports, pc.
module pc_regfile
  import pc_regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 3,
  parameter int PC_RD_OFS = 8,
  parameter int LINK_OFS  = 4,
  parameter int RESET_PC  = 0,
  parameter int BANKED    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [3:0]               waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     link_we,
  input  logic [DATA_W-1:0]        pc_next,
  input  logic                     pc_stall,
  input  logic                     mode_irq,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  output logic [DATA_W-1:0]        pc
);

  logic [DATA_W-1:0]   gpr [15];
  logic [DATA_W-1:0]   sp_irq;
  logic [DATA_W-1:0]   lr_irq;
  logic [15*DATA_W-1:0] view;
  logic [DATA_W-1:0]   link_val;
  logic                irq;
  logic                wr_gpr;
  logic                wr_bank;

  assign irq      = (BANKED != 0) && mode_irq;
  assign wr_gpr   = we && (waddr != REG_PC);
  assign wr_bank  = irq && (waddr == REG_SP || waddr == REG_LR);
  assign link_val = pc + DATA_W'(LINK_OFS);

  // Link update is issued last so it wins over a write to R14.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) gpr[i] <= '0;
    end else begin
      if (wr_gpr && !wr_bank) gpr[waddr] <= wdata;
      if (link_we && !irq) gpr[REG_LR] <= link_val;
    end
  end

  generate
    if (BANKED != 0) begin : g_bank
      always_ff @(posedge clk) begin
        if (reset) begin
          sp_irq <= '0;
          lr_irq <= '0;
        end else begin
          if (wr_gpr && irq && waddr == REG_SP) sp_irq <= wdata;
          if (wr_gpr && irq && waddr == REG_LR) lr_irq <= wdata;
          if (link_we && irq) lr_irq <= link_val;
        end
      end
    end else begin : g_nobank
      assign sp_irq = '0;
      assign lr_irq = '0;
    end
  endgenerate

  // A write to R15 is a branch: it beats both pc_next and stall.
  always_ff @(posedge clk) begin
    if (reset)
      pc <= DATA_W'(RESET_PC);
    else if (we && waddr == REG_PC)
      pc <= wdata;
    else if (!pc_stall)
      pc <= pc_next;
  end

  // Active-bank view; mode change needs no copy, just a mux swap.
  always_comb begin
    view = '0;
    for (int i = 0; i < 15; i++)
      view[i*DATA_W +: DATA_W] = gpr[i];
    if (irq) begin
      view[13*DATA_W +: DATA_W] = sp_irq;
      view[14*DATA_W +: DATA_W] = lr_irq;
    end
  end

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      pc_regfile_rdport #(
        .DATA_W   (DATA_W),
        .PC_RD_OFS(PC_RD_OFS)
      ) u_rd (
        .addr    (rd_addr[4*g +: 4]),
        .view    (view),
        .pc      (pc),
        .wr_en   (wr_gpr),
        .waddr   (waddr),
        .wdata   (wdata),
        .link_we (link_we),
        .link_val(link_val),
        .data    (rd_data[DATA_W*g +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pc_regfile.sv
// Self-checking bench for pc_regfile: directed table plus random vs model.
// Drives all ports; checks reads mid-cycle and pc after each edge.
module tb_pc_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        link_we;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        mode_irq;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic [31:0] pc;

  int tests = 0;
  int fails = 0;

  pc_regfile dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr),
    .wdata(wdata), .link_we(link_we), .pc_next(pc_next),
    .pc_stall(pc_stall), .mode_irq(mode_irq),
    .rd_addr(rd_addr), .rd_data(rd_data), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Reference state: plain arrays, usr bank and irq bank for SP/LR.
  logic [31:0] m_usr [15];
  logic [31:0] m_irq [2];
  logic [31:0] m_pc;

  function automatic logic [31:0] stored(int a, logic md);
    if (md && a >= 13) return m_irq[a-13];
    return m_usr[a];
  endfunction

  function automatic logic [31:0] exp_rd(int a);
    if (a == 15) return m_pc + 32'd8;
    if (link_we && a == 14) return m_pc + 32'd4;
    if (we && int'(waddr) == a) return wdata;
    return stored(a, mode_irq);
  endfunction

  task automatic put(int a, logic md, logic [31:0] v);
    if (md && a >= 13) m_irq[a-13] = v;
    else m_usr[a] = v;
  endtask

  task automatic model_edge();
    logic [31:0] lv;
    if (reset) begin
      for (int i = 0; i < 15; i++) m_usr[i] = '0;
      m_irq[0] = '0;
      m_irq[1] = '0;
      m_pc = '0;
    end else begin
      lv = m_pc + 32'd4;
      if (we && waddr != 4'd15) put(int'(waddr), mode_irq, wdata);
      if (link_we) put(14, mode_irq, lv);
      if (we && waddr == 4'd15) m_pc = wdata;
      else if (!pc_stall) m_pc = pc_next;
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        lnk;
    logic [31:0] pn;
    logic        st;
    logic        md;
    logic [3:0]  ra;
    logic [31:0] er;
    logic [31:0] ep;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(logic rs, logic w, logic [3:0] wa,
    logic [31:0] wd, logic lk, logic [31:0] pn, logic st, logic md,
    logic [3:0] ra, logic [31:0] er, logic [31:0] ep);
    vec_t v;
    v.rst = rs; v.we = w; v.wa = wa; v.wd = wd; v.lnk = lk;
    v.pn = pn; v.st = st; v.md = md; v.ra = ra; v.er = er; v.ep = ep;
    return v;
  endfunction

  task automatic idle();
    reset = 0; we = 0; waddr = 0; wdata = 0; link_we = 0;
    pc_next = 0; pc_stall = 1; mode_irq = 0; rd_addr = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    check("reset_pc", pc, 32'h0);
    for (int a = 0; a < 15; a += 3) begin
      rd_addr = {4'(a + 2), 4'(a + 1), 4'(a)};
      #1;
      for (int p = 0; p < 3; p++)
        check($sformatf("reset_r%0d", a + p),
              rd_data[32*p +: 32], 32'h0);
    end
    rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    for (int p = 0; p < 3; p++)
      check("reset_r15", rd_data[32*p +: 32], 32'h8);

    vt[0]  = mk(0,1,3,32'hDEADBEEF,0,0,1,0,3,32'hDEADBEEF,0);
    vt[1]  = mk(0,0,0,0,0,32'h100,0,0,3,32'hDEADBEEF,32'h100);
    vt[2]  = mk(0,1,14,32'h55,1,0,1,0,14,32'h104,32'h100);
    vt[3]  = mk(0,0,0,0,0,32'h104,1,0,14,32'h104,32'h100);
    vt[4]  = mk(0,0,0,0,0,32'h104,1,0,15,32'h108,32'h100);
    vt[5]  = mk(0,0,0,0,0,32'h104,1,0,15,32'h108,32'h100);
    vt[6]  = mk(0,0,0,0,0,32'h104,0,0,15,32'h108,32'h104);
    vt[7]  = mk(0,1,15,32'h200,0,32'h108,1,0,15,32'h10C,32'h200);
    vt[8]  = mk(0,1,13,32'h11,0,0,1,0,13,32'h11,32'h200);
    vt[9]  = mk(0,1,13,32'h22,0,0,1,1,13,32'h22,32'h200);
    vt[10] = mk(0,0,0,0,0,0,1,1,13,32'h22,32'h200);
    vt[11] = mk(0,0,0,0,0,0,1,0,13,32'h11,32'h200);
    vt[12] = mk(0,0,0,0,0,0,1,1,3,32'hDEADBEEF,32'h200);
    vt[13] = mk(0,0,0,0,0,0,1,0,14,32'h104,32'h200);
    vt[14] = mk(0,0,0,0,0,0,1,1,14,32'h0,32'h200);
    vt[15] = mk(0,1,15,32'hFFFFFFFC,0,0,1,0,15,32'h208,32'hFFFFFFFC);
    vt[16] = mk(0,0,0,0,0,0,1,0,15,32'h4,32'hFFFFFFFC);
    vt[17] = mk(1,1,5,32'h99,1,0,1,0,3,32'hDEADBEEF,32'h0);
    vt[18] = mk(0,0,0,0,0,0,1,0,5,32'h0,32'h0);
    vt[19] = mk(0,0,0,0,0,0,1,0,3,32'h0,32'h0);

    for (int i = 0; i < 20; i++) begin
      reset = vt[i].rst; we = vt[i].we; waddr = vt[i].wa;
      wdata = vt[i].wd; link_we = vt[i].lnk; pc_next = vt[i].pn;
      pc_stall = vt[i].st; mode_irq = vt[i].md;
      rd_addr = {8'h00, vt[i].ra};
      @(negedge clk);
      check($sformatf("vec%0d_rd", i), rd_data[31:0], vt[i].er);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pc", i), pc, vt[i].ep);
    end

    // Random phase against the model, starting from a fresh reset.
    idle();
    reset = 1;
    model_edge();
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 31) == 0);
      we       = $urandom_range(0, 1) == 1;
      waddr    = 4'($urandom_range(0, 15));
      if (waddr == 4'd15 && $urandom_range(0, 3) != 0)
        waddr = 4'($urandom_range(0, 14));
      wdata    = $urandom;
      link_we  = ($urandom_range(0, 3) == 0);
      pc_next  = $urandom;
      pc_stall = $urandom_range(0, 1) == 1;
      mode_irq = $urandom_range(0, 1) == 1;
      rd_addr  = 12'($urandom);
      @(negedge clk);
      if (!reset)
        for (int p = 0; p < 3; p++)
          check($sformatf("rnd%0d_p%0d", n, p), rd_data[32*p +: 32],
                exp_rd(int'(rd_addr[4*p +: 4])));
      model_edge();
      @(posedge clk); #1;
      check($sformatf("rnd%0d_pc", n), pc, m_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_regfile.md
PC_REGFILE -- requirements
Module: pc_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, 32, register and PC width.
REQ-002 The block SHALL have parameter NUM_RD, 3, number of read ports, legal range 1..4.
REQ-003 The block SHALL have parameter PC_RD_OFS, 8, value added to PC when R15 is read.
REQ-004 The block SHALL have parameter LINK_OFS, 4, value added to PC for the link write.
REQ-005 The block SHALL have parameter RESET_PC, 0, PC value after reset.
REQ-006 The block SHALL have parameter BANKED, 1, enabling IRQ-banked R13/R14 when 1.
REQ-007 The block SHALL have port clk, input, 1, clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 The block SHALL have port we, input, 1, general register write enable.
REQ-010 The block SHALL have port waddr, input, 4, write address.
REQ-011 The block SHALL have port wdata, input, DATA_W, write data.
REQ-012 The block SHALL have port link_we, input, 1, write PC+LINK_OFS into R14.
REQ-013 The block SHALL have port pc_next, input, DATA_W, sequential next PC.
REQ-014 The block SHALL have port pc_stall, input, 1, hold PC.
REQ-015 The block SHALL have port mode_irq, input, 1, selects IRQ bank for R13/R14.
REQ-016 The block SHALL have port rd_addr, input, 4*NUM_RD, packed read addresses, port i at bits [4i+3:4i].
REQ-017 The block SHALL have port rd_data, output, DATA_W*NUM_RD, packed read data, port i at [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-018 The block SHALL have port pc, output, DATA_W, current PC register.

Function
REQ-019 Storage SHALL be R0..R14 (plus R13_irq/R14_irq when BANKED=1) and a separate PC register; all update only on rising clk.
REQ-020 we=1, waddr in 0..14: target register SHALL take wdata next edge; with BANKED=1 and mode_irq=1, waddr 13/14 SHALL target R13_irq/R14_irq.
REQ-021 we=1, waddr=15: PC SHALL take wdata next edge, overriding pc_next and pc_stall (branch/flush priority).
REQ-022 Otherwise PC SHALL take pc_next when pc_stall=0 and hold when pc_stall=1.
REQ-023 link_we=1: active-bank R14 SHALL take current pc+LINK_OFS (mod 2^DATA_W); simultaneous we to R14 SHALL lose to link_we.
REQ-024 Reads SHALL be combinational, zero latency, all NUM_RD ports independent.
REQ-025 rd_addr=15 SHALL return pc+PC_RD_OFS, modulo 2^DATA_W, no bypass applied.
REQ-026 rd_addr in 0..14 SHALL return same-cycle write value when that register is being written (link value first, then wdata), else stored value (write-first bypass).
REQ-027 Bank selection for reads SHALL use current mode_irq; a mode change SHALL take effect the same cycle with no register copy.
REQ-028 BANKED=0: mode_irq SHALL be ignored.
REQ-029 While reset=1, rd_data SHALL read as stored values (zero after first reset edge); no bypass beyond REQ-026 rules.

Reset
REQ-030 On a rising clk with reset=1, all general and banked registers SHALL become 0 and PC SHALL become RESET_PC.
REQ-031 reset SHALL override we, link_we and pc_stall in the same cycle; a write pending at reset SHALL be discarded.
REQ-032 pc output SHALL equal RESET_PC in the cycle after reset is sampled.

Structure
REQ-033 Package pc_regfile_pkg SHALL hold REG_SP=13, REG_LR=14, REG_PC=15 and the 4-bit register-address type.
REQ-034 One sub-module pc_regfile_rdport SHALL implement a single read mux with PC offset and bypass, instantiated NUM_RD times via generate.

Verification
REQ-035 Reset then read all ports addr 0..14 -> all 0; rd_addr=15 -> RESET_PC+8; pc=RESET_PC.
REQ-036 we=1, waddr=3, wdata=0xDEADBEEF, rd_addr0=3 same cycle -> rd_data0=0xDEADBEEF same cycle and after edge.
REQ-037 pc=0x100, pc_stall=1, pc_next=0x104 for 3 cycles -> pc stays 0x100; stall released -> 0x104; we waddr=15 wdata=0x200 with stall=1 -> pc=0x200.
REQ-038 pc=0x100, link_we=1 and we waddr=14 wdata=0x55 -> R14=0x104.
REQ-039 mode_irq=0 write R13=0x11; mode_irq=1 write R13=0x22 -> mode 1 reads 0x22, mode 0 reads 0x11; R0-R12 unaffected.
REQ-040 pc=0xFFFFFFFC, rd_addr=15 -> 0x00000004 (wrap); reset asserted with we=1 waddr=5 -> R5=0.
